// File: rtl/alu_issue_stage.sv
// Command-issue stage for the 4-bit ALU: FIFO-buffered {op,a,b} commands, one settle cycle, result capture.
// Optional macro ALU_ISSUE_DIVZERO_EN: op 3 with b == 0 forces res_f = 4'hF and raises res_err.
module alu_issue_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_f,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_f,
  output logic       res_zero,
  output logic       res_carry,
  output logic       res_err,
  output logic [4:0] level
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_q, state_d;
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]    count_q, count_d;
  logic [3:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [3:0]    res_f_q, res_f_d;
  logic          res_zero_q, res_zero_d;
  logic          res_carry_q, res_carry_d;
  logic          res_err_q, res_err_d;
  logic          push, pop, capture, divz;
  logic [4:0]    sum5;

  assign cmd_ready = (count_q < DEPTH_L);
  assign push      = cmd_valid && cmd_ready;
  assign sum5      = {1'b0, alu_a_q} + {1'b0, alu_b_q};

`ifdef ALU_ISSUE_DIVZERO_EN
  assign divz = (alu_op_q == 3'd3) && (alu_b_q == 4'h0);
`else
  assign divz = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (res_ready) state_d = (count_q != '0) ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; pops look only at the registered count, so a same-cycle push is never bypassed
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE:    pop = (count_q != '0);
      EXEC:    capture = 1'b1;
      DONE:    pop = res_ready && (count_q != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q + 5'(push) - 5'(pop);
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_f_d     = res_f_q;
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop) begin
      rptr_d                       = rptr_q + AW'(1);
      {alu_op_d, alu_a_d, alu_b_d} = mem_q[rptr_q];
    end
    // Carry/borrow come from the latched operands, never from alu_f
    if (capture) begin
      res_f_d    = divz ? 4'hF : alu_f;
      res_zero_d = (res_f_d == 4'h0);
      res_err_d  = divz;
      unique case (alu_op_q)
        3'd0:    res_carry_d = sum5[4];
        3'd1:    res_carry_d = (alu_a_q < alu_b_q);
        default: res_carry_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_f_q     <= '0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_f_q     <= res_f_d;
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = (state_q == DONE);
  assign res_f     = res_f_q;
  assign res_zero  = res_zero_q;
  assign res_carry = res_carry_q;
  assign res_err   = res_err_q;
  assign level     = count_q;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command-issue stage sitting directly upstream of the 4-bit ALU (`ALU_4bit`). It accepts `{op, a, b}` commands over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the ALU's `a`/`b`/`op` inputs, holds them stable for a settle cycle, then captures the ALU result `f` with status flags. The captured result is presented downstream over a second valid/ready handshake.

## Interface

- `DEPTH`, default 4: command FIFO entries; power of 2, range 2..16.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  FIFO can accept; equals `count < DEPTH`.
- `cmd_op`  input  3  ALU opcode (0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not-a).
- `cmd_a`, `cmd_b`  input  4 each  operands.
- `alu_a`, `alu_b`  output  4 each  to ALU `a`/`b`.
- `alu_op`  output  3  to ALU `op`.
- `alu_f`  input  4  from ALU `f`.
- `res_valid`  output  1  result held.
- `res_ready`  input  1  downstream accepts.
- `res_f`  output  4  captured result.
- `res_zero`  output  1  `res_f == 0`.
- `res_carry`  output  1  op 0: carry out of 5-bit `a+b`; op 1: borrow (`a < b`); otherwise 0.
- `res_err`  output  1  divide-by-zero flag (see Configuration).
- `level`  output  5  current FIFO occupancy, 0..DEPTH.

## Operation

- FIFO:
  - Push on `cmd_valid & cmd_ready`.
  - Read and write pointers wrap modulo DEPTH.
  - No bypass: a command pushed while the FIFO is empty is not poppable in the same cycle.
  - Push and pop in the same cycle are allowed when neither full nor empty; `level` is unchanged.
- FSM states and transitions:
  - IDLE: if `level != 0`, pop the head into `alu_a/alu_b/alu_op` and go to EXEC.
  - EXEC: one settle cycle with the ALU inputs stable. At the end of the cycle, capture `alu_f` into `res_f`, compute the flags, set `res_valid`, and go to DONE.
  - DONE: hold all `res_*` and `alu_*` outputs.
    - On `res_ready`: if `level != 0`, pop the next command and go to EXEC; otherwise go to IDLE.
    - Without `res_ready`: stay in DONE indefinitely (backpressure). The FIFO keeps accepting commands until full.
- `res_valid` is 1 only in DONE; it is cleared on the handshake edge.
- Arithmetic: `res_f` is the ALU's 4-bit truncated output. `res_carry` is computed inside this block from the latched operands, never from `alu_f`.
- `alu_*` retain the last issued command while in IDLE.
- Reset values (asynchronous assertion):
  - State IDLE; pointers and `level` = 0.
  - `alu_a/alu_b/alu_op` = 0.
  - `res_f` = 0; `res_valid`, `res_zero`, `res_carry`, `res_err` = 0.
  - `cmd_ready` = 1.
- Reset mid-operation discards all buffered commands and any undelivered result.

## Timing

- Accept at edge E0 → pop at E1 (state IDLE) → capture at E2 → `res_valid` high after E2. Minimum latency is 2 cycles.
- Back-to-back throughput with `res_ready` held high: one result every 2 cycles.
- `cmd_ready` and `level` update on the edge after a push or pop.
- The ALU is combinational. Its inputs change only on the pop edge, so `alu_f` is sampled one full cycle after the inputs change.

## Configuration

- Macro `ALU_ISSUE_DIVZERO_EN`.
- Defined: for op 3 with `b == 0`, `res_err` = 1 and `res_f` = 4'hF, ignoring `alu_f`. `res_zero` is computed on the forced value, so it is 0.
- Undefined: `res_err` is tied to 0 and `res_f` is always `alu_f`. A divide by zero passes through whatever the ALU produces.

## Test plan

- Single command `op=0, a=3, b=10` after reset → `res_valid` 2 cycles after accept; `res_f=13`, `res_zero=0`, `res_carry=0`.
- `op=0, a=12, b=9` → `res_f=5`, `res_carry=1`. Then `op=1, a=4, b=4` → `res_f=0`, `res_zero=1`, `res_carry=0`.
- Hold `res_ready=0` and push 5 commands with DEPTH=4:
  - Required: one command in EXEC/DONE plus 4 in the FIFO, after which `cmd_ready=0` and `level=4`.
  - Release `res_ready`: 5 results delivered in order, one every 2 cycles.
- `op=3, a=8, b=0`:
  - With `ALU_ISSUE_DIVZERO_EN` defined: `res_f=15`, `res_err=1`.
  - Without: `res_err=0`.
- Assert `rst` in the middle of EXEC with 3 commands queued → all outputs reach their reset values immediately; after release, `level=0` and no stale `res_valid`.
